perfect_classifier: RTL and testbench

PERFECT_CLASSIFIER -- requirements
Module: perfect_classifier

---
 rtl/perfect_classifier_if.sv | 23 ++
 rtl/perfect_classifier.sv | 143 ++++++++++++++
 tb/tb_perfect_classifier.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/perfect_classifier_if.sv
// Handshake and result bundle for the perfect-number classifier.
// The master drives go/x; the slave (classifier) drives status and results.
interface perfect_classifier_if #(
  parameter int WIDTH = 16
);
  logic             go;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             done;
  logic [1:0]       cls;
  logic [WIDTH-1:0] sum_out;
  logic             sat;

  modport master (
    output go, x,
    input  busy, done, cls, sum_out, sat
  );

  modport slave (
    input  go, x,
    output busy, done, cls, sum_out, sat
  );
endinterface

// File: rtl/perfect_classifier.sv
// Classifies n as deficient/perfect/abundant by summing its proper divisors,
// testing each candidate i in 1..floor(n/2) with a restoring shift-subtract divider.
module perfect_classifier #(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 clr,
  perfect_classifier_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DIV_LOAD,
    DIV_STEP,
    ACC,
    CLASSIFY,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_i;
  logic [WIDTH-1:0] r_sum;
  logic             r_satAcc;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [CW-1:0]    r_bitCnt;
  logic [1:0]       r_cls;
  logic [WIDTH-1:0] r_sumOut;
  logic             r_sat;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_noBorrow;
  logic [WIDTH:0]   w_sumAdd;
  logic [WIDTH-1:0] w_iNext;

  // The remainder is always below i <= 2^(WIDTH-1), so the low WIDTH bits of the
  // difference are exact whenever no borrow occurs.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_noBorrow = (w_shift >= {1'b0, r_i});
  assign w_diff     = w_shift[WIDTH-1:0] - r_i;
  assign w_sumAdd   = {1'b0, r_sum} + {1'b0, r_i};
  assign w_iNext    = r_i + WIDTH'(1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= IDLE;
      r_n      <= '0;
      r_m      <= '0;
      r_i      <= '0;
      r_sum    <= '0;
      r_satAcc <= 1'b0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_bitCnt <= '0;
      r_cls    <= 2'b00;
      r_sumOut <= '0;
      r_sat    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.go) begin
            r_n     <= bus.x;
            r_busy  <= 1'b1;
            r_state <= INIT;
          end
        end
        INIT: begin
          r_sum    <= '0;
          r_i      <= WIDTH'(1);
          r_satAcc <= 1'b0;
          r_m      <= {1'b0, r_n[WIDTH-1:1]};
          r_state  <= (r_n[WIDTH-1:1] != '0) ? DIV_LOAD : CLASSIFY;
        end
        DIV_LOAD: begin
          r_dvd    <= r_n;
          r_rem    <= '0;
          r_bitCnt <= CW'(WIDTH - 1);
          r_state  <= DIV_STEP;
        end
        DIV_STEP: begin
          r_rem <= w_noBorrow ? w_diff : w_shift[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          if (r_bitCnt == '0) begin
            r_state <= ACC;
          end else begin
            r_bitCnt <= r_bitCnt - CW'(1);
          end
        end
        ACC: begin
          if (r_rem == '0) begin
            if (w_sumAdd[WIDTH]) begin
              r_sum    <= '1;
              r_satAcc <= 1'b1;
            end else begin
              r_sum <= w_sumAdd[WIDTH-1:0];
            end
          end
          r_i     <= w_iNext;
          r_state <= (w_iNext <= r_m) ? DIV_LOAD : CLASSIFY;
        end
        CLASSIFY: begin
          // Zero has an empty divisor sum equal to itself but is not perfect.
          if (r_satAcc || (r_sum > r_n)) begin
            r_cls <= 2'b10;
          end else if ((r_sum == r_n) && (r_n != '0)) begin
            r_cls <= 2'b01;
          end else begin
            r_cls <= 2'b00;
          end
          r_sumOut <= r_sum;
          r_sat    <= r_satAcc;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          if (!bus.go) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.cls     = r_cls;
  assign bus.sum_out = r_sumOut;
  assign bus.sat     = r_sat;
endmodule

// File: tb/tb_perfect_classifier.sv
// Scoreboard bench for perfect_classifier at WIDTH=16 and WIDTH=8: a divisor-sum
// reference model queues expected results and latency, compared when done rises.
module tb_perfect_classifier;
  logic clk;
  logic clr;

  perfect_classifier_if #(.WIDTH(16)) bus16 ();
  perfect_classifier_if #(.WIDTH(8))  bus8 ();

  perfect_classifier #(.WIDTH(16)) dut16 (.clk(clk), .clr(clr), .bus(bus16));
  perfect_classifier #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(bus8));

  typedef struct {
    string       tag;
    logic [31:0] sum;
    logic [1:0]  cls;
    logic        sat;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [31:0] xv, input string tag);
    exp_t    e;
    longint  n;
    longint  s;
    longint  maxv;
    maxv = (64'd1 << w) - 1;
    n    = longint'(xv) & maxv;
    s    = 0;
    for (longint d = 1; d <= n / 2; d++) begin
      if (n % d == 0) s += d;
    end
    e.tag = tag;
    e.sat = (s > maxv);
    e.sum = e.sat ? 32'(maxv) : 32'(s);
    if (e.sat || s > n)        e.cls = 2'b10;
    else if (s == n && n != 0) e.cls = 2'b01;
    else                       e.cls = 2'b00;
    e.lat = 2 + int'(n / 2) * (w + 2);
    return e;
  endfunction

  task automatic setGo(input int w, input logic v);
    if (w == 16) bus16.go = v;
    else         bus8.go = v;
  endtask

  task automatic setX(input int w, input logic [31:0] xv);
    if (w == 16) bus16.x = xv[15:0];
    else         bus8.x = xv[7:0];
  endtask

  function automatic logic doneOf(input int w);
    return (w == 16) ? bus16.done : bus8.done;
  endfunction

  function automatic logic busyOf(input int w);
    return (w == 16) ? bus16.busy : bus8.busy;
  endfunction

  function automatic logic [31:0] sumOf(input int w);
    return (w == 16) ? {16'b0, bus16.sum_out} : {24'b0, bus8.sum_out};
  endfunction

  function automatic logic [1:0] clsOf(input int w);
    return (w == 16) ? bus16.cls : bus8.cls;
  endfunction

  function automatic logic satOf(input int w);
    return (w == 16) ? bus16.sat : bus8.sat;
  endfunction

  // mode 0: plain run, 1: disturb x/go while busy, 2: clr pulse at edge 100
  task automatic applyStimulus(input int w, input logic [31:0] xv, input int mode, input string tag);
    exp_t e;
    int   edgeN;
    bit   seen;
    bit   aborted;
    int   doneCount;
    sbq.push_back(model(w, xv, tag));
    @(negedge clk);
    setX(w, xv);
    setGo(w, 1'b1);
    @(posedge clk);
    edgeN   = 0;
    seen    = 0;
    aborted = 0;
    while (!seen && !aborted && edgeN < sbq[0].lat + 20) begin
      @(posedge clk);
      edgeN++;
      #1;
      if (mode == 1 && edgeN == 50) begin
        setX(w, 32'd12);
        setGo(w, 1'b0);
      end
      if (mode == 1 && edgeN == 53) setGo(w, 1'b1);
      if (mode == 2 && edgeN == 100) begin
        clr = 1'b1;
        setGo(w, 1'b0);
        #1;
        checkOutput({tag, "_clr_busy"}, 32'(busyOf(w)), 32'd0);
        checkOutput({tag, "_clr_done"}, 32'(doneOf(w)), 32'd0);
        checkOutput({tag, "_clr_cls"}, 32'(clsOf(w)), 32'd0);
        checkOutput({tag, "_clr_sum"}, sumOf(w), 32'd0);
        checkOutput({tag, "_clr_sat"}, 32'(satOf(w)), 32'd0);
        aborted = 1;
      end
      if (!aborted && doneOf(w)) seen = 1;
    end
    e = sbq.pop_front();
    if (aborted) begin
      @(negedge clk);
      clr = 1'b0;
      doneCount = 0;
      for (int k = 0; k < 300; k++) begin
        @(posedge clk);
        #1;
        if (doneOf(w) || busyOf(w)) doneCount++;
      end
      checkOutput({tag, "_abort_idle"}, 32'(doneCount), 32'd0);
      return;
    end
    checkOutput({tag, "_seen_done"}, 32'(seen), 32'd1);
    if (!seen) begin
      setGo(w, 1'b0);
      return;
    end
    checkOutput({tag, "_latency"}, 32'(edgeN), 32'(e.lat));
    checkOutput({tag, "_sum"}, sumOf(w), e.sum);
    checkOutput({tag, "_cls"}, 32'(clsOf(w)), 32'(e.cls));
    checkOutput({tag, "_sat"}, 32'(satOf(w)), 32'(e.sat));
    checkOutput({tag, "_busy"}, 32'(busyOf(w)), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_hold"}, 32'(doneOf(w)), 32'd1);
    setGo(w, 1'b0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_drop"}, 32'(doneOf(w)), 32'd0);
    checkOutput({tag, "_sum_held"}, sumOf(w), e.sum);
  endtask

  initial begin
    bus16.go = 1'b0;
    bus16.x  = '0;
    bus8.go  = 1'b0;
    bus8.x   = '0;
    clr      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus16.busy), 32'd0);
    checkOutput("rst_done", 32'(bus16.done), 32'd0);
    checkOutput("rst_cls", 32'(bus16.cls), 32'd0);
    checkOutput("rst_sum", {16'b0, bus16.sum_out}, 32'd0);
    checkOutput("rst_sat", 32'(bus16.sat), 32'd0);
    checkOutput("rst8_done", 32'(bus8.done), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    applyStimulus(16, 32'd28, 0, "x28");
    applyStimulus(16, 32'd6, 0, "x6");
    applyStimulus(16, 32'd8, 0, "x8");
    applyStimulus(16, 32'd12, 0, "x12");
    applyStimulus(16, 32'd28, 2, "x28_abort");
    applyStimulus(16, 32'd28, 0, "x28_rerun");
    applyStimulus(16, 32'd28, 1, "x28_disturb");
    applyStimulus(16, 32'd0, 0, "x0");
    applyStimulus(16, 32'd1, 0, "x1");
    applyStimulus(16, 32'd496, 0, "x496");
    applyStimulus(16, 32'($urandom_range(2, 300)), 0, "rand_a");
    applyStimulus(16, 32'($urandom_range(2, 300)), 0, "rand_b");
    applyStimulus(8, 32'd240, 0, "w8_x240");
    applyStimulus(8, 32'd255, 0, "w8_x255");
    applyStimulus(8, 32'd6, 0, "w8_x6");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
